// File: rtl/ps2_key_receiver.sv
// +----------------------------------------------------------------------------+
// | ps2_key_receiver: PS/2 keyboard frame receiver with F0/E0 prefix decoding   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module ps2_key_receiver #(
  parameter int          FILTER_LEN    = 3,
  parameter logic [15:0] TIMEOUT       = 16'd10000,
  parameter bit          CHECK_PARITY  = 1'b0,
  parameter bit          DECODE_PREFIX = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_clk,
  input  logic       key_data,
  output logic [7:0] data,
  output logic       changed,
  output logic       released,
  output logic       extended,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic           kclk_meta_q, kclk_meta_d, kclk_sync_q, kclk_sync_d;
  logic           kdat_meta_q, kdat_meta_d, kdat_sync_q, kdat_sync_d;
  logic           filt_q, filt_d, filt_prev_q, filt_prev_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  state_t         state_q, state_d;
  logic [7:0]     shreg_q, shreg_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic           par_q, par_d;
  logic           brk_q, brk_d, ext_q, ext_d;
  logic [15:0]    tmo_q, tmo_d;
  logic [7:0]     data_q, data_d;
  logic           changed_q, changed_d, released_q, released_d, extended_q, extended_d;
  logic           parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic           fall;
  logic           bit_in;
  logic [15:0]    tmo_inc;

  // Clock line changes filtered level only after FILTER_LEN consecutive differing samples
  always_comb begin
    kclk_meta_d = key_clk;
    kclk_sync_d = kclk_meta_q;
    kdat_meta_d = key_data;
    kdat_sync_d = kdat_meta_q;
    filt_d      = filt_q;
    filt_cnt_d  = '0;
    filt_prev_d = filt_q;
    if (kclk_sync_q != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) filt_d = kclk_sync_q;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign fall    = filt_prev_q & ~filt_q;
  assign bit_in  = kdat_sync_q;
  assign tmo_inc = tmo_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    tmo_d        = tmo_q;
    data_d       = data_q;
    released_d   = released_q;
    extended_d   = extended_q;
    changed_d    = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (!bit_in) begin
            state_d   = S_RECV;
            bit_cnt_d = '0;
          end
        end
        S_RECV: begin
          shreg_d   = {bit_in, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = bit_in;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (!bit_in) begin
            frame_err_d = 1'b1;
          end else if (CHECK_PARITY && ((^{shreg_q, par_q}) == 1'b0)) begin
            parity_err_d = 1'b1;
          end else if (DECODE_PREFIX && shreg_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (DECODE_PREFIX && shreg_q == 8'hE0) begin
            ext_d = 1'b1;
          end else begin
            data_d     = shreg_q;
            released_d = brk_q;
            extended_d = ext_q;
            changed_d  = 1'b1;
            brk_d      = 1'b0;
            ext_d      = 1'b0;
          end
        end
      endcase
    end else if (state_q != S_IDLE) begin
      tmo_d = tmo_inc;
      if (tmo_inc == TIMEOUT) begin
        tmo_d       = '0;
        state_d     = S_IDLE;
        frame_err_d = 1'b1;
        brk_d       = 1'b0;
        ext_d       = 1'b0;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kclk_meta_q  <= 1'b1;
      kclk_sync_q  <= 1'b1;
      kdat_meta_q  <= 1'b1;
      kdat_sync_q  <= 1'b1;
      filt_q       <= 1'b1;
      filt_prev_q  <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      tmo_q        <= '0;
      data_q       <= '0;
      changed_q    <= 1'b0;
      released_q   <= 1'b0;
      extended_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      kclk_meta_q  <= kclk_meta_d;
      kclk_sync_q  <= kclk_sync_d;
      kdat_meta_q  <= kdat_meta_d;
      kdat_sync_q  <= kdat_sync_d;
      filt_q       <= filt_d;
      filt_prev_q  <= filt_prev_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      tmo_q        <= tmo_d;
      data_q       <= data_d;
      changed_q    <= changed_d;
      released_q   <= released_d;
      extended_q   <= extended_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data       = data_q;
  assign changed    = changed_q;
  assign released   = released_q;
  assign extended   = extended_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_receiver.sv
// +----------------------------------------------------------------------------+
// | tb_ps2_key_receiver: directed self-checking bench for ps2_key_receiver      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_key_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_clk = 1'b1;
  logic       key_data = 1'b1;
  logic [7:0] data0, data1;
  logic       chg0, rel0, ext0, pe0, fe0;
  logic       chg1, rel1, ext1, pe1, fe1;

  int n_checks = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;
  int fe_cnt   = 0;
  int pe_cnt   = 0;
  int chg1_cnt = 0;
  int pe1_cnt  = 0;
  logic [9:0] chg_log [0:63];

  always #7 clk = ~clk;

  ps2_key_receiver dut0 (
    .clk(clk), .reset(reset), .key_clk(key_clk), .key_data(key_data),
    .data(data0), .changed(chg0), .released(rel0), .extended(ext0),
    .parity_err(pe0), .frame_err(fe0)
  );

  ps2_key_receiver #(.CHECK_PARITY(1'b1)) dut1 (
    .clk(clk), .reset(reset), .key_clk(key_clk), .key_data(key_data),
    .data(data1), .changed(chg1), .released(rel1), .extended(ext1),
    .parity_err(pe1), .frame_err(fe1)
  );

  // Every high cycle of a pulse is counted, so a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (chg0) begin
      if (chg_cnt < 64) chg_log[chg_cnt] = {rel0, ext0, data0};
      chg_cnt++;
    end
    if (fe0)  fe_cnt++;
    if (pe0)  pe_cnt++;
    if (chg1) chg1_cnt++;
    if (pe1)  pe1_cnt++;
  end

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  // 105 ns bit: data set while clock high, clock low for 52 ns
  task automatic ps2_bit(input logic b);
    key_data = b;
    #26 key_clk = 1'b0;
    #52 key_clk = 1'b1;
    #27;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic stp, input int gap);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(stp);
    key_data = 1'b1;
    #(gap);
  endtask

  task automatic test_reset;
    repeat (4) @(negedge clk);
    n_checks++; if (data0 !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data0); end
    n_checks++; if (chg0 !== 1'b0) begin n_fail++; $display("FAIL reset_changed got %b want 0", chg0); end
    n_checks++; if (rel0 !== 1'b0) begin n_fail++; $display("FAIL reset_released got %b want 0", rel0); end
    n_checks++; if (ext0 !== 1'b0) begin n_fail++; $display("FAIL reset_extended got %b want 0", ext0); end
    n_checks++; if (fe0 !== 1'b0 || pe1 !== 1'b0) begin n_fail++; $display("FAIL reset_errs got fe=%b pe=%b want 0 0", fe0, pe1); end
    reset = 1'b0;
    #200;
  endtask

  task automatic test_single;
    int c0;
    c0 = chg_cnt;
    send_frame(8'h14, 1'b1, 1'b1, 300);
    n_checks++; if (chg_cnt - c0 !== 1) begin n_fail++; $display("FAIL single_changed_count got %0d want 1", chg_cnt - c0); end
    n_checks++; if (data0 !== 8'h14) begin n_fail++; $display("FAIL single_data got %h want 14", data0); end
    n_checks++; if (rel0 !== 1'b0 || ext0 !== 1'b0) begin n_fail++; $display("FAIL single_flags got rel=%b ext=%b want 0 0", rel0, ext0); end
    n_checks++; if (fe_cnt !== 0) begin n_fail++; $display("FAIL single_no_frame_err got %0d want 0", fe_cnt); end
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = chg_cnt;
    send_frame(8'h14, odd_par(8'h14), 1'b1, 0);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 0);
    send_frame(8'h14, odd_par(8'h14), 1'b1, 300);
    n_checks++; if (chg_cnt - c0 !== 2) begin n_fail++; $display("FAIL b2b_changed_count got %0d want 2", chg_cnt - c0); end
    n_checks++; if (chg_log[c0] !== {1'b0, 1'b0, 8'h14}) begin n_fail++; $display("FAIL b2b_first got %h want 014", chg_log[c0]); end
    n_checks++; if (chg_log[c0 + 1] !== {1'b1, 1'b0, 8'h14}) begin n_fail++; $display("FAIL b2b_second got %h want 214", chg_log[c0 + 1]); end
    n_checks++; if (rel0 !== 1'b1) begin n_fail++; $display("FAIL b2b_released_held got %b want 1", rel0); end
  endtask

  task automatic test_prefix;
    int c0;
    c0 = chg_cnt;
    send_frame(8'hE0, odd_par(8'hE0), 1'b1, 200);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1, 200);
    n_checks++; if (chg_cnt - c0 !== 0) begin n_fail++; $display("FAIL prefix_no_changed got %0d want 0", chg_cnt - c0); end
    send_frame(8'h75, odd_par(8'h75), 1'b1, 300);
    n_checks++; if (chg_cnt - c0 !== 1) begin n_fail++; $display("FAIL prefix_changed_count got %0d want 1", chg_cnt - c0); end
    n_checks++; if ({rel0, ext0, data0} !== {1'b1, 1'b1, 8'h75}) begin n_fail++; $display("FAIL prefix_ext_brk got %b%b %h want 1 1 75", rel0, ext0, data0); end
    send_frame(8'h1C, odd_par(8'h1C), 1'b1, 300);
    n_checks++; if (chg_cnt - c0 !== 2) begin n_fail++; $display("FAIL prefix_next_count got %0d want 2", chg_cnt - c0); end
    n_checks++; if ({rel0, ext0, data0} !== {1'b0, 1'b0, 8'h1C}) begin n_fail++; $display("FAIL prefix_cleared got %b%b %h want 0 0 1c", rel0, ext0, data0); end
  endtask

  task automatic test_stop_err;
    int c0, f0;
    c0 = chg_cnt; f0 = fe_cnt;
    send_frame(8'h1C, odd_par(8'h1C), 1'b0, 300);
    n_checks++; if (fe_cnt - f0 !== 1) begin n_fail++; $display("FAIL stop_frame_err got %0d want 1", fe_cnt - f0); end
    n_checks++; if (chg_cnt - c0 !== 0) begin n_fail++; $display("FAIL stop_no_changed got %0d want 0", chg_cnt - c0); end
    n_checks++; if (data0 !== 8'h1C) begin n_fail++; $display("FAIL stop_data_held got %h want 1c", data0); end
  endtask

  task automatic test_parity;
    int c0, c1, p1, p0;
    c0 = chg_cnt; c1 = chg1_cnt; p1 = pe1_cnt; p0 = pe_cnt;
    // 0x1C has three ones, so parity 1 makes the total even (bad), parity 0 is good
    send_frame(8'h1C, 1'b1, 1'b1, 300);
    n_checks++; if (pe1_cnt - p1 !== 1) begin n_fail++; $display("FAIL par_err_pulse got %0d want 1", pe1_cnt - p1); end
    n_checks++; if (chg1_cnt - c1 !== 0) begin n_fail++; $display("FAIL par_bad_no_changed got %0d want 0", chg1_cnt - c1); end
    n_checks++; if (chg_cnt - c0 !== 1 || pe_cnt - p0 !== 0) begin n_fail++; $display("FAIL par_ignored chg=%0d pe=%0d want 1 0", chg_cnt - c0, pe_cnt - p0); end
    send_frame(8'h1C, 1'b0, 1'b1, 300);
    n_checks++; if (chg1_cnt - c1 !== 1 || data1 !== 8'h1C) begin n_fail++; $display("FAIL par_good got chg=%0d data=%h want 1 1c", chg1_cnt - c1, data1); end
    n_checks++; if (pe1_cnt - p1 !== 1) begin n_fail++; $display("FAIL par_good_no_err got %0d want 1", pe1_cnt - p1); end
  endtask

  task automatic test_timeout_and_reset;
    int c0, f0;
    c0 = chg_cnt; f0 = fe_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    key_data = 1'b1;
    repeat (10100) @(negedge clk);
    n_checks++; if (fe_cnt - f0 !== 1) begin n_fail++; $display("FAIL tmo_frame_err got %0d want 1", fe_cnt - f0); end
    n_checks++; if (chg_cnt - c0 !== 0 || data0 !== 8'h1C) begin n_fail++; $display("FAIL tmo_no_data chg=%0d data=%h want 0 1c", chg_cnt - c0, data0); end
    send_frame(8'h29, odd_par(8'h29), 1'b1, 300);
    n_checks++; if (chg_cnt - c0 !== 1 || data0 !== 8'h29) begin n_fail++; $display("FAIL tmo_recover chg=%0d data=%h want 1 29", chg_cnt - c0, data0); end
    n_checks++; if (fe_cnt - f0 !== 1) begin n_fail++; $display("FAIL tmo_idle_quiet got %0d want 1", fe_cnt - f0); end
    c0 = chg_cnt; f0 = fe_cnt;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    reset = 1'b1;
    key_data = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({data0, chg0, rel0, ext0, fe0} !== 12'h000) begin n_fail++; $display("FAIL midreset_outputs got %h %b%b%b%b want 00 0000", data0, chg0, rel0, ext0, fe0); end
    reset = 1'b0;
    #2000;
    n_checks++; if (chg_cnt - c0 !== 0 || fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL midreset_silent chg=%0d fe=%0d want 0 0", chg_cnt - c0, fe_cnt - f0); end
    send_frame(8'h5A, odd_par(8'h5A), 1'b1, 300);
    n_checks++; if (chg_cnt - c0 !== 1 || data0 !== 8'h5A) begin n_fail++; $display("FAIL midreset_next chg=%0d data=%h want 1 5a", chg_cnt - c0, data0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_prefix();
    test_stop_err();
    test_parity();
    test_timeout_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
